hazard_sequencer: RTL
=====================

Name: hazard_sequencer

Overview:
- Pipeline hazard/stall controller for the 5-stage RV32I core.
- Consumes decoded control (RegReadD, RegWriteE, MemToRegE, jump/branch flags) and handshakes from the data-memory port and a multi-cycle MUL/DIV unit.
- Produces per-stage stall/flush, sequences multi-cycle waits via an FSM, and keeps a stall-cycle performance counter.

Parameters:
- MD_TIMEOUT, 64, max MD_WAIT cycles before abort; must be >=2.
- MEM_TIMEOUT, 16, max MEM_WAIT cycles before abort; must be >=2.
- CNT_W, 32, width of StallCnt.

Ports:
- clk  in  1  core clock
- rst  in  1  reset, asynchronous, active-high
- RegReadD  in  2  [1]=rs1 used, [0]=rs2 used by the ID instruction
- Rs1D, Rs2D  in  5 each  ID source registers
- RdE  in  5  EX destination register
- RegWriteE  in  3  EX write mode; 0 = no register write
- MemToRegE  in  1  EX instruction is a load
- BranchE  in  1  branch taken, resolved in EX
- JalrE  in  1  JALR in EX
- JalD  in  1  JAL in ID
- MdReqE  in  1  multi-cycle op occupies EX
- MdDone  in  1  multi-cycle result valid (1-cycle pulse)
- DMemReqM  in  1  load/store in MEM needs the memory port
- DMemAck  in  1  memory port completes the access this cycle
- StallF, StallD, StallE, StallM, StallW  out  1 each  hold stage register
- FlushD, FlushE, FlushM, FlushW  out  1 each  load bubble into stage register
- MdStart  out  1  1-cycle start pulse to the MUL/DIV unit
- Err  out  1  sticky timeout flag
- Busy  out  1  FSM not in RUN
- StallCnt  out  CNT_W  cycles with StallF=1

Behaviour:
- FSM states: RUN=0, MD_WAIT=1, MEM_WAIT=2. Registered state plus wait counter (width fits max(MD_TIMEOUT, MEM_TIMEOUT)). Stall/flush/MdStart are Mealy-decoded from state and inputs.
- While rst=1:
  - state=RUN, counter=0, Err=0, StallCnt=0.
  - FlushD..FlushW=1; all stalls=0; MdStart=0; Busy=0.
- Load-use term LU is true when all hold: RegWriteE!=0, MemToRegE=1, RdE!=0, and ((RegReadD[1] and Rs1D==RdE) or (RegReadD[0] and Rs2D==RdE)).
- RUN decode; first matching rule wins, all unnamed outputs are 0:
  1. DMemReqM and !DMemAck: StallF/D/E/M=1, FlushW=1; next=MEM_WAIT, counter=1.
  2. MdReqE: MdStart=1, StallF/D/E=1, FlushM=1; next=MD_WAIT, counter=1.
  3. BranchE or JalrE: FlushD=1, FlushE=1 (overrides LU and JalD).
  4. LU: StallF=1, StallD=1, FlushE=1.
  5. JalD: FlushD=1.
- MD_WAIT:
  - MdDone=0 and counter<MD_TIMEOUT: StallF/D/E=1, FlushM=1, counter++.
  - MdDone=1: apply RUN rules 1,3,4,5 (MdReqE is ignored this cycle so the EX op advances); next=RUN, or MEM_WAIT if rule 1 fires.
  - counter==MD_TIMEOUT and no MdDone: Err<=1, next=RUN; outputs as for MdDone=1.
  - MdStart is never asserted in MD_WAIT.
- MEM_WAIT:
  - DMemAck=0 and counter<MEM_TIMEOUT: StallF/D/E/M=1, FlushW=1, counter++.
  - DMemAck=1 or timeout (timeout sets Err): outputs per RUN rules 2..5; next=RUN, or MD_WAIT if rule 2 fires (MdStart=1 that cycle).
- Busy = (state!=RUN).
- StallCnt increments on every clk edge where StallF=1 and rst=0; wraps modulo 2^CNT_W.
- Err stays set until rst.
- A stall and a flush of the same stage are never asserted together.
- Reset mid-wait: asynchronous return to RUN with reset outputs; a pending MdDone/DMemAck arriving after reset is ignored in RUN.

Test Plan:
1. lw x5 then add x6,x5,x1. RUN with MemToRegE=1, RegWriteE=3'b010, RdE=5, RegReadD=2'b11, Rs1D=5 -> StallF=StallD=FlushE=1 for exactly 1 cycle. StallCnt 0->1. Repeat with RdE=0 -> no stall.
2. MdReqE=1 in RUN, MdDone 4 cycles later -> MdStart=1 for 1 cycle only. StallF/D/E=1 and FlushM=1 for 4 cycles. Busy=1 for 4 cycles. Return to RUN. StallCnt +4. Err=0.
3. DMemReqM=1, DMemAck low 3 cycles then high -> StallF..M=1 and FlushW=1 for 3 cycles. Release on the ack cycle. Busy=1 for 3 cycles.
4. BranchE=1 with LU=1 and JalD=1 in the same cycle -> FlushD=FlushE=1, StallF=0. Then JalD alone -> FlushD=1 only.
5. MD_TIMEOUT=8, MdReqE held, MdDone never -> 8 stall cycles, Err=1, state RUN. Assert rst mid-wait in a rerun -> all stalls 0, flushes 1, Err=0 immediately, without waiting for a clk edge.
6. MdReqE in RUN while DMemReqM=1 and DMemAck=0 -> MEM_WAIT first, MdStart=0. On the ack cycle -> MdStart=1, next=MD_WAIT.

Source files
------------

// File: rtl/hazard_sequencer.sv
// Pipeline hazard/stall controller for the 5-stage RV32I core.
// Ports: decoded hazard inputs (RegReadD, Rs1D, Rs2D, RdE, RegWriteE,
//   MemToRegE, BranchE, JalrE, JalD), MUL/DIV handshake (MdReqE, MdDone,
//   MdStart), data-memory handshake (DMemReqM, DMemAck), per-stage
//   Stall*/Flush*, sticky timeout Err, Busy, and StallCnt (StallF cycles).
module hazard_sequencer #(
    parameter int MD_TIMEOUT  = 64,
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       RegReadD,
    input  logic [4:0]       Rs1D,
    input  logic [4:0]       Rs2D,
    input  logic [4:0]       RdE,
    input  logic [2:0]       RegWriteE,
    input  logic             MemToRegE,
    input  logic             BranchE,
    input  logic             JalrE,
    input  logic             JalD,
    input  logic             MdReqE,
    input  logic             MdDone,
    input  logic             DMemReqM,
    input  logic             DMemAck,
    output logic             StallF,
    output logic             StallD,
    output logic             StallE,
    output logic             StallM,
    output logic             StallW,
    output logic             FlushD,
    output logic             FlushE,
    output logic             FlushM,
    output logic             FlushW,
    output logic             MdStart,
    output logic             Err,
    output logic             Busy,
    output logic [CNT_W-1:0] StallCnt
);

    localparam int MAXT = (MD_TIMEOUT > MEM_TIMEOUT) ? MD_TIMEOUT : MEM_TIMEOUT;
    localparam int CW   = $clog2(MAXT + 1);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MD_WAIT  = 2'd1,
        MEM_WAIT = 2'd2
    } state_t;

    state_t        state, state_nx;
    logic [CW-1:0] cnt, cnt_nx;
    logic          err_set;
    logic          lu;
    logic          decode;
    logic          allow_mem;
    logic          allow_md;

    assign lu = (RegWriteE != 3'd0) && MemToRegE && (RdE != 5'd0) &&
                ((RegReadD[1] && (Rs1D == RdE)) ||
                 (RegReadD[0] && (Rs2D == RdE)));

    assign Busy = (state != RUN);

    always_comb begin
        state_nx  = state;
        cnt_nx    = cnt;
        err_set   = 1'b0;
        decode    = 1'b0;
        allow_mem = 1'b0;
        allow_md  = 1'b0;
        StallF    = 1'b0;
        StallD    = 1'b0;
        StallE    = 1'b0;
        StallM    = 1'b0;
        StallW    = 1'b0;
        FlushD    = 1'b0;
        FlushE    = 1'b0;
        FlushM    = 1'b0;
        FlushW    = 1'b0;
        MdStart   = 1'b0;

        // Work out whether this cycle holds a wait or decodes normally;
        // on release the wait's own trigger rule is masked out.
        case (state)
            MD_WAIT: begin
                if (!MdDone && (cnt < CW'(MD_TIMEOUT))) begin
                    {StallF, StallD, StallE, FlushM} = 4'b1111;
                    cnt_nx = cnt + CW'(1);
                end else begin
                    decode    = 1'b1;
                    allow_mem = 1'b1;
                    err_set   = !MdDone;
                end
            end
            MEM_WAIT: begin
                if (!DMemAck && (cnt < CW'(MEM_TIMEOUT))) begin
                    {StallF, StallD, StallE, StallM, FlushW} = 5'b11111;
                    cnt_nx = cnt + CW'(1);
                end else begin
                    decode   = 1'b1;
                    allow_md = 1'b1;
                    err_set  = !DMemAck;
                end
            end
            default: begin
                decode    = 1'b1;
                allow_mem = 1'b1;
                allow_md  = 1'b1;
            end
        endcase

        if (decode) begin
            state_nx = RUN;
            cnt_nx   = '0;
            if (allow_mem && DMemReqM && !DMemAck) begin
                {StallF, StallD, StallE, StallM, FlushW} = 5'b11111;
                state_nx = MEM_WAIT;
                cnt_nx   = CW'(1);
            end else if (allow_md && MdReqE) begin
                {MdStart, StallF, StallD, StallE, FlushM} = 5'b11111;
                state_nx = MD_WAIT;
                cnt_nx   = CW'(1);
            end else if (BranchE || JalrE) begin
                {FlushD, FlushE} = 2'b11;
            end else if (lu) begin
                {StallF, StallD, FlushE} = 3'b111;
            end else if (JalD) begin
                FlushD = 1'b1;
            end
        end

        // Reset is asynchronous, so its output image must be as well.
        if (rst) begin
            {StallF, StallD, StallE, StallM, StallW} = 5'b00000;
            {FlushD, FlushE, FlushM, FlushW}         = 4'b1111;
            MdStart = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= RUN;
            cnt      <= '0;
            Err      <= 1'b0;
            StallCnt <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            Err   <= Err | err_set;
            if (StallF) begin
                StallCnt <= StallCnt + CNT_W'(1);
            end
        end
    end

endmodule
